// File: rtl/pc_fetch_ctrl.sv
// Nibbler fetch/branch controller: latches instruction bytes from ROM, issues non-branch ops, loads the PC on branches.
// Optional CALL/RET with a one-entry link register when NIBBLER_CALL_RET_EN is defined.
module pc_fetch_ctrl #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic [AW-1:0] addr,
  input  logic          phase,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          carry,
  input  logic          zero,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  output logic [AW-1:0] newaddr,
  output logic          enable,
  output logic          busy
);

  localparam int AB = AW - 4;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_ADDR, S_BRANCH} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [AB-1:0]   abyte_q, abyte_d;
  logic [AW-1:0]   newaddr_q, newaddr_d;
  logic            busy_q, busy_d;
`ifdef NIBBLER_CALL_RET_EN
  logic [AW-1:0]   lr_q, lr_d;
`endif

  logic [3:0]      opcode;
  logic            two_word;
  logic            is_ret;
  logic            taken;
  logic            enable_c;
  logic            ir_valid_c;
  logic [AW-1:0]   newaddr_c;

  assign rom_addr = addr;
  assign opcode   = ir_q[DW-1:DW-4];

  always_comb begin
    two_word = (opcode >= 4'h8) && (opcode <= 4'hC);
    is_ret   = 1'b0;
`ifdef NIBBLER_CALL_RET_EN
    if (opcode == 4'hD) two_word = 1'b1;
    is_ret = (opcode == 4'hE);
`endif
    case (opcode)
      4'h8:    taken = carry;
      4'h9:    taken = ~carry;
      4'hA:    taken = zero;
      4'hB:    taken = ~zero;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    abyte_d    = abyte_q;
    busy_d     = busy_q;
    enable_c   = 1'b0;
    ir_valid_c = 1'b0;
    newaddr_c  = newaddr_q;
`ifdef NIBBLER_CALL_RET_EN
    lr_d       = lr_q;
`endif
    // Each state acts only in its own phase; a mismatched phase simply holds.
    case (state_q)
      S_FETCH: begin
        if (!phase) begin
          ir_d    = rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (phase) begin
          state_d = S_FETCH;
          if (two_word) begin
            state_d = S_ADDR;
            busy_d  = 1'b1;
          end else if (is_ret) begin
`ifdef NIBBLER_CALL_RET_EN
            enable_c  = 1'b1;
            newaddr_c = lr_q;
`endif
          end else begin
            ir_valid_c = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (!phase) begin
          abyte_d = rom_data[AB-1:0];
          state_d = S_BRANCH;
        end
      end
      S_BRANCH: begin
        if (phase) begin
          state_d = S_FETCH;
          busy_d  = 1'b0;
          if (taken) begin
            enable_c  = 1'b1;
            newaddr_c = {ir_q[3:0], abyte_q};
          end
`ifdef NIBBLER_CALL_RET_EN
          // The PC already points past the address byte here, i.e. the return address.
          if (opcode == 4'hD) lr_d = addr;
`endif
        end
      end
      default: state_d = S_FETCH;
    endcase
    newaddr_d = newaddr_c;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      abyte_q   <= '0;
      newaddr_q <= '0;
      busy_q    <= 1'b0;
`ifdef NIBBLER_CALL_RET_EN
      lr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      abyte_q   <= abyte_d;
      newaddr_q <= newaddr_d;
      busy_q    <= busy_d;
`ifdef NIBBLER_CALL_RET_EN
      lr_q      <= lr_d;
`endif
    end
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_c;
  assign enable   = enable_c;
  assign newaddr  = newaddr_c;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: a simple PC drives addr/phase; an instruction-level model predicts every cycle.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        Rst;
  logic [11:0] addr;
  logic        phase;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        carry;
  logic        zero;
  logic [7:0]  ir;
  logic        ir_valid;
  logic [11:0] newaddr;
  logic        enable;
  logic        busy;

  logic [7:0]  rom [4096];
  logic [11:0] pc_start;

  int checks = 0;
  int failures = 0;

  // observation captures used by the literal checks
  logic [11:0] cap_newaddr;
  int en_count, busy_count, iv_count;

  // instruction-level model state
  logic [11:0] m_pc, m_na, m_lr;

  pc_fetch_ctrl #(.AW(12), .DW(8)) dut (
    .clk(clk), .Rst(Rst), .addr(addr), .phase(phase), .rom_addr(rom_addr),
    .rom_data(rom_data), .carry(carry), .zero(zero), .ir(ir), .ir_valid(ir_valid),
    .newaddr(newaddr), .enable(enable), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  // PC: bumps on the fetch-phase edge, loads newaddr on an execute-phase edge when enabled.
  always @(posedge clk or posedge Rst) begin
    if (Rst) begin
      addr  <= pc_start;
      phase <= 1'b0;
    end else if (!phase) begin
      addr  <= addr + 12'd1;
      phase <= 1'b1;
    end else begin
      addr  <= enable ? newaddr : addr;
      phase <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Check one cycle's outputs at the current negedge, then advance one cycle.
  task automatic expect_cycle(input string tag, input bit iv, input bit en, input bit bz,
                              input logic [11:0] na);
    chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, iv});
    chk({tag, ".enable"},   {31'd0, enable},   {31'd0, en});
    chk({tag, ".busy"},     {31'd0, busy},     {31'd0, bz});
    chk({tag, ".newaddr"},  {20'd0, newaddr},  {20'd0, na});
    if (enable) begin
      en_count++;
      cap_newaddr = newaddr;
    end
    if (busy) busy_count++;
    if (ir_valid) iv_count++;
    $display("cycle %s addr=%03h phase=%0d ir=%02h iv=%0d en=%0d na=%03h busy=%0d",
             tag, addr, phase, ir, ir_valid, enable, newaddr, busy);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [11:0] start, input int cycles);
    pc_start = start;
    Rst = 1'b1;
    #1;
    chk("rst_busy_now", {31'd0, busy}, 32'd0);
    chk("rst_enable_now", {31'd0, enable}, 32'd0);
    repeat (cycles) @(negedge clk);
    chk("rst_ir", {24'd0, ir}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_newaddr", {20'd0, newaddr}, 32'd0);
    chk("rst_enable", {31'd0, enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    Rst = 1'b0;
    m_pc = start;
    m_na = 12'h000;
    m_lr = 12'h000;
    en_count = 0;
    busy_count = 0;
    iv_count = 0;
  endtask

  task automatic run_prog(input int n);
    logic [7:0]  op, ab;
    logic [3:0]  hi;
    logic [11:0] target;
    bit          two_word, is_ret, tk;
    for (int i = 0; i < n; i++) begin
      op = rom[m_pc];
      hi = op[7:4];
      two_word = (hi >= 4'h8) && (hi <= 4'hC);
      is_ret = 1'b0;
`ifdef NIBBLER_CALL_RET_EN
      if (hi == 4'hD) two_word = 1'b1;
      is_ret = (hi == 4'hE);
`endif
      chk("fetch_addr", {20'd0, addr}, {20'd0, m_pc});
      expect_cycle("fetch", 1'b0, 1'b0, 1'b0, m_na);
      chk("decode_ir", {24'd0, ir}, {24'd0, op});
      if (two_word) begin
        ab = rom[m_pc + 12'd1];
        target = {op[3:0], ab};
        case (hi)
          4'h8:    tk = carry;
          4'h9:    tk = !carry;
          4'hA:    tk = zero;
          4'hB:    tk = !zero;
          default: tk = 1'b1;
        endcase
        expect_cycle("decode", 1'b0, 1'b0, 1'b0, m_na);
        expect_cycle("addr", 1'b0, 1'b0, 1'b1, m_na);
        if (tk) m_na = target;
        expect_cycle("branch", 1'b0, tk, 1'b1, m_na);
        if (hi == 4'hD) m_lr = m_pc + 12'd2;
        m_pc = tk ? target : m_pc + 12'd2;
      end else if (is_ret) begin
        m_na = m_lr;
        expect_cycle("ret", 1'b0, 1'b1, 1'b0, m_na);
        m_pc = m_lr;
      end else begin
        expect_cycle("exec", 1'b1, 1'b0, 1'b0, m_na);
        m_pc = m_pc + 12'd1;
      end
    end
  endtask

  initial begin
    Rst = 1'b1;
    carry = 1'b0;
    zero = 1'b0;
    pc_start = 12'h400;
    cap_newaddr = 12'h000;
    for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    rom[12'h000] = 8'hC3; rom[12'h001] = 8'h59;   // JMP 0x359
    rom[12'h010] = 8'h8A; rom[12'h011] = 8'h12;   // JC 0xA12
    rom[12'h020] = 8'hD1; rom[12'h021] = 8'h00;   // CALL 0x100 (plain op without the feature)
    rom[12'h100] = 8'hE0;                          // RET
    rom[12'h030] = 8'hBF; rom[12'h031] = 8'hFF;   // JNZ 0xFFF
    rom[12'h040] = 8'hAF; rom[12'h041] = 8'hFF;   // JZ 0xFFF
    rom[12'h050] = 8'h95; rom[12'h051] = 8'h67;   // JNC 0x567
    rom[12'h060] = 8'hE0; rom[12'h061] = 8'hD0;
    @(negedge clk);

    // all-zero ROM: plain instructions only
    do_reset(12'h400, 6);
    run_prog(4);
    chk("zero_rom_enables", en_count, 0);
    chk("zero_rom_ir_valids", iv_count, 4);

    // JMP
    do_reset(12'h000, 2);
    run_prog(1);
    chk("jmp_target", {20'd0, cap_newaddr}, 32'h359);
    chk("jmp_enables", en_count, 1);
    chk("jmp_busy_cycles", busy_count, 2);
    run_prog(2);

    // JC not taken then taken
    carry = 1'b0;
    do_reset(12'h010, 2);
    run_prog(1);
    chk("jc_nt_enables", en_count, 0);
    chk("jc_nt_next_pc", {20'd0, addr}, 32'h012);
    run_prog(1);
    carry = 1'b1;
    do_reset(12'h010, 2);
    run_prog(1);
    chk("jc_t_target", {20'd0, cap_newaddr}, 32'hA12);
    chk("jc_t_enables", en_count, 1);
    run_prog(1);

    // JNZ/JZ with zero=1, top-of-memory target and wrap back to 0x000
    zero = 1'b1;
    carry = 1'b0;
    do_reset(12'h030, 2);
    run_prog(1);
    chk("jnz_enables", en_count, 0);
    chk("jnz_next_pc", {20'd0, addr}, 32'h032);
    do_reset(12'h040, 2);
    run_prog(1);
    chk("jz_target", {20'd0, cap_newaddr}, 32'hFFF);
    run_prog(2);
    chk("wrap_jmp_target", {20'd0, cap_newaddr}, 32'h359);
    zero = 1'b0;

    // JNC taken
    do_reset(12'h050, 2);
    run_prog(1);
    chk("jnc_target", {20'd0, cap_newaddr}, 32'h567);

    // reset while in ADDR aborts the branch
    do_reset(12'h000, 2);
    @(negedge clk);
    @(negedge clk);
    chk("addr_state_busy", {31'd0, busy}, 32'd1);
    do_reset(12'h000, 3);
    run_prog(1);
    chk("post_abort_enables", en_count, 1);
    chk("post_abort_target", {20'd0, cap_newaddr}, 32'h359);

`ifdef NIBBLER_CALL_RET_EN
    do_reset(12'h020, 2);
    run_prog(1);
    chk("call_target", {20'd0, cap_newaddr}, 32'h100);
    run_prog(1);
    chk("ret_target", {20'd0, cap_newaddr}, 32'h022);
    chk("call_ret_enables", en_count, 2);
    run_prog(1);
`else
    do_reset(12'h060, 2);
    run_prog(2);
    chk("e0_d0_enables", en_count, 0);
    chk("e0_d0_ir_valids", iv_count, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
